gen_wave_sequencer: RTL and testbench

GEN_WAVE_SEQUENCER -- requirements
Module: gen_wave_sequencer

---
 rtl/gen_wave_sequencer_pkg.sv | 28 ++
 rtl/gen_wave_sequencer_if.sv | 40 ++++
 rtl/gen_amp_scaler.sv | 36 +++
 rtl/gen_wave_sequencer.sv | 123 ++++++++++++
 tb/tb_gen_wave_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gen_wave_sequencer_pkg.sv
// Shared types and fixed-point constants for the waveform sequencer.
// Samples and gains are signed Q4.28; the raw product is Q8.56.
package gen_wave_sequencer_pkg;

  localparam int GEN_DATA_WIDTH = 32;
  localparam int GEN_INT_BITS   = 4;
  localparam int GEN_LUT_ADDR   = 8;
  localparam int GEN_FRAC_BITS  = GEN_DATA_WIDTH - GEN_INT_BITS;
  localparam int GEN_PROD_WIDTH = 2 * GEN_DATA_WIDTH;

  // Unity gain in the sample format.
  localparam logic [GEN_DATA_WIDTH-1:0] AMP_RESET = GEN_DATA_WIDTH'(1) << GEN_FRAC_BITS;

  typedef enum logic [1:0] {
    COS   = 2'd0,
    SIN   = 2'd1,
    TRIAN = 2'd2,
    SQUA  = 2'd3
  } wave_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SCALE = 2'd2,
    PUSH  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/gen_wave_sequencer_if.sv
// Config, LUT and FIFO signals of the waveform sequencer.
// master = sequencer side, slave = the surrounding LUT/FIFO/control logic.
interface gen_wave_sequencer_if
  import gen_wave_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = GEN_DATA_WIDTH,
  parameter int LUT_ADDR   = GEN_LUT_ADDR
);

  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [1:0]            cfg_wave;
  logic [LUT_ADDR-1:0]   cfg_phase_inc;
  logic [DATA_WIDTH-1:0] cfg_amp;
  logic [15:0]           cfg_num;
  logic                  start;
  logic                  stop;
  logic                  lut_en;
  logic [1:0]            lut_sel;
  logic [LUT_ADDR-1:0]   lut_addr;
  logic [DATA_WIDTH-1:0] lut_data;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DATA_WIDTH-1:0] fifo_wdata;
  logic                  busy;
  logic                  done;

  modport master (
    input  cfg_valid, cfg_wave, cfg_phase_inc, cfg_amp, cfg_num,
    input  start, stop, lut_data, fifo_full,
    output cfg_ready, lut_en, lut_sel, lut_addr, fifo_wr_en, fifo_wdata, busy, done
  );

  modport slave (
    output cfg_valid, cfg_wave, cfg_phase_inc, cfg_amp, cfg_num,
    output start, stop, lut_data, fifo_full,
    input  cfg_ready, lut_en, lut_sel, lut_addr, fifo_wr_en, fifo_wdata, busy, done
  );

endinterface

// File: rtl/gen_amp_scaler.sv
// Signed Q4.28 x Q4.28 multiply, truncated back to Q4.28 with saturation.
// Purely combinational; the caller registers the result.
module gen_amp_scaler
  import gen_wave_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = GEN_DATA_WIDTH,
  parameter int INT_BITS   = GEN_INT_BITS
) (
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [DATA_WIDTH-1:0] amp,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int FRAC = DATA_WIDTH - INT_BITS;
  localparam int PW   = 2 * DATA_WIDTH;

  logic signed [PW-1:0] prod;
  logic [INT_BITS:0]    guard;
  logic                 unused_lsb;

  always_comb begin
    prod = $signed({{DATA_WIDTH{sample[DATA_WIDTH-1]}}, sample})
         * $signed({{DATA_WIDTH{amp[DATA_WIDTH-1]}}, amp});
    // Result fits only if every bit above the kept field copies its sign bit.
    guard      = prod[PW-1 -: INT_BITS+1];
    unused_lsb = ^prod[FRAC-1:0];
    if (&guard || ~|guard) begin
      result = prod[FRAC +: DATA_WIDTH];
    end else if (prod[PW-1]) begin
      result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/gen_wave_sequencer.sv
// Fetches LUT words, scales them by a Q4.28 gain and pushes them into a FIFO.
// One sample per 3 cycles, first write 3 cycles after start; holds the sample in PUSH while fifo_full.
module gen_wave_sequencer
  import gen_wave_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = GEN_DATA_WIDTH,
  parameter int INT_BITS   = GEN_INT_BITS,
  parameter int LUT_ADDR   = GEN_LUT_ADDR
) (
  input logic                  clk,
  input logic                  rst_n,
  gen_wave_sequencer_if.master sq
);

  seq_state_t            state_q, state_d;
  wave_sel_t             wave_q, wave_d;
  logic [LUT_ADDR-1:0]   inc_q, inc_d;
  logic [LUT_ADDR-1:0]   phase_q, phase_d;
  logic [DATA_WIDTH-1:0] amp_q, amp_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic [15:0]           num_q, num_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] scaled;
  logic                  wr_en;
  logic                  last;

  gen_amp_scaler #(
    .DATA_WIDTH (DATA_WIDTH),
    .INT_BITS   (INT_BITS)
  ) u_scaler (
    .sample (sq.lut_data),
    .amp    (amp_q),
    .result (scaled)
  );

  assign wr_en = (state_q == PUSH) && !sq.fifo_full;
  // num of zero means free-running, so no sample is ever the last one.
  assign last  = (num_q != 16'd0) && ((cnt_q + 16'd1) == num_q);

  always_comb begin
    state_d  = state_q;
    wave_d   = wave_q;
    inc_d    = inc_q;
    amp_d    = amp_q;
    num_d    = num_q;
    phase_d  = phase_q;
    cnt_d    = cnt_q;
    sample_d = sample_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sq.cfg_valid) begin
          wave_d = wave_sel_t'(sq.cfg_wave);
          inc_d  = sq.cfg_phase_inc;
          amp_d  = sq.cfg_amp;
          num_d  = sq.cfg_num;
        end
        if (sq.start) begin
          state_d = FETCH;
          phase_d = '0;
          cnt_d   = '0;
        end
      end
      FETCH: state_d = sq.stop ? IDLE : SCALE;
      SCALE: begin
        sample_d = scaled;
        state_d  = sq.stop ? IDLE : PUSH;
      end
      PUSH: begin
        if (wr_en) begin
          phase_d = phase_q + inc_q;
          cnt_d   = cnt_q + 16'd1;
        end
        if (sq.stop) begin
          state_d = IDLE;
        end else if (wr_en) begin
          if (last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wave_q   <= COS;
      inc_q    <= LUT_ADDR'(1);
      amp_q    <= DATA_WIDTH'(AMP_RESET);
      num_q    <= '0;
      phase_q  <= '0;
      cnt_q    <= '0;
      sample_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wave_q   <= wave_d;
      inc_q    <= inc_d;
      amp_q    <= amp_d;
      num_q    <= num_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      sample_q <= sample_d;
      done_q   <= done_d;
    end
  end

  assign sq.cfg_ready  = (state_q == IDLE);
  assign sq.busy       = (state_q != IDLE);
  assign sq.lut_en     = (state_q == FETCH);
  assign sq.lut_sel    = (state_q == FETCH) ? 2'(wave_q) : 2'b00;
  assign sq.lut_addr   = (state_q == FETCH) ? phase_q : '0;
  assign sq.fifo_wr_en = wr_en;
  assign sq.fifo_wdata = sample_q;
  assign sq.done       = done_q;

endmodule

// File: tb/tb_gen_wave_sequencer.sv
// Directed bench for gen_wave_sequencer: reset defaults, phase wrap, scaling, stalls, aborts, config lockout.
module tb_gen_wave_sequencer;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic [31:0] lut_value = 32'h0;
  logic        lut_en_d  = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  int          cyc         = 0;
  int          wr_cnt      = 0;
  int          done_cnt    = 0;
  int          last_wr_cyc = 0;
  int          done_cyc    = 0;
  logic        done_busy   = 1'b1;
  logic [31:0] last_wdata  = 32'h0;
  logic [1:0]  last_sel    = 2'b00;
  logic [7:0]  addr_log[$];

  logic [7:0]  exp_wrap[5] = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};

  gen_wave_sequencer_if #(.DATA_WIDTH(32), .LUT_ADDR(8)) sq ();

  gen_wave_sequencer #(
    .DATA_WIDTH (32),
    .INT_BITS   (4),
    .LUT_ADDR   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (sq)
  );

  always #5 clk = ~clk;

  // LUT model: word valid only in the cycle after the read strobe.
  always @(posedge clk) lut_en_d <= sq.lut_en;
  assign sq.lut_data = lut_en_d ? lut_value : 32'h0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (sq.lut_en === 1'b1) begin
      addr_log.push_back(sq.lut_addr);
      last_sel = sq.lut_sel;
    end
    if (sq.fifo_wr_en === 1'b1) begin
      wr_cnt      = wr_cnt + 1;
      last_wdata  = sq.fifo_wdata;
      last_wr_cyc = cyc;
    end
    if (sq.done === 1'b1) begin
      done_cnt  = done_cnt + 1;
      done_cyc  = cyc;
      done_busy = sq.busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input logic [1:0] wave, input logic [7:0] inc,
                         input logic [31:0] amp, input logic [15:0] num);
    sq.cfg_valid     = 1'b1;
    sq.cfg_wave      = wave;
    sq.cfg_phase_inc = inc;
    sq.cfg_amp       = amp;
    sq.cfg_num       = num;
    tick();
    sq.cfg_valid = 1'b0;
  endtask

  task automatic start_run();
    sq.start = 1'b1;
    tick();
    sq.start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    for (int i = 0; i < max_cyc; i++) begin
      if (sq.busy === 1'b0) break;
      tick();
    end
    check({tag, "_idle"}, 64'(sq.busy), 64'd0);
  endtask

  task automatic run_one(input logic [31:0] amp, input logic [31:0] lut,
                         input logic [31:0] exp, input string tag);
    int w0;
    set_cfg(2'd1, 8'd1, amp, 16'd1);
    lut_value = lut;
    w0 = wr_cnt;
    start_run();
    wait_idle(20, tag);
    tick();
    check({tag, "_wdata"}, 64'(last_wdata), 64'(exp));
    check({tag, "_count"}, 64'(wr_cnt - w0), 64'd1);
  endtask

  initial begin
    int          w0;
    int          d0;
    int          a0;
    logic [31:0] held;
    logic        stall_ok;

    sq.cfg_valid     = 1'b0;
    sq.cfg_wave      = 2'd0;
    sq.cfg_phase_inc = 8'd0;
    sq.cfg_amp       = 32'h0;
    sq.cfg_num       = 16'd0;
    sq.start         = 1'b0;
    sq.stop          = 1'b0;
    sq.fifo_full     = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_cfg_ready", 64'(sq.cfg_ready), 64'd1);
    check("rst_busy", 64'(sq.busy), 64'd0);
    check("rst_lut_en", 64'(sq.lut_en), 64'd0);
    check("rst_lut_addr", 64'(sq.lut_addr), 64'd0);
    check("rst_wr_en", 64'(sq.fifo_wr_en), 64'd0);
    check("rst_wdata", 64'(sq.fifo_wdata), 64'd0);
    check("rst_done", 64'(sq.done), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Reset defaults: wave 0, inc 1, amp 1.0, continuous
    lut_value = 32'h0800_0000;
    start_run();
    check("t1_fetch_lut_en", 64'(sq.lut_en), 64'd1);
    check("t1_addr0", 64'(sq.lut_addr), 64'h00);
    check("t1_sel", 64'(sq.lut_sel), 64'd0);
    check("t1_busy", 64'(sq.busy), 64'd1);
    tick();
    check("t1_scale_no_wr", 64'(sq.fifo_wr_en), 64'd0);
    tick();
    check("t1_latency_wr_en", 64'(sq.fifo_wr_en), 64'd1);
    check("t1_wdata", 64'(sq.fifo_wdata), 64'h0800_0000);
    tick();
    check("t1_addr1", 64'(sq.lut_addr), 64'h01);
    repeat (3) tick();
    check("t1_addr2", 64'(sq.lut_addr), 64'h02);
    w0 = wr_cnt;
    check("t1_writes", 64'(w0), 64'd2);
    sq.stop = 1'b1;
    tick();
    sq.stop = 1'b0;
    check("t1_stop_fetch_idle", 64'(sq.busy), 64'd0);
    tick();
    check("t1_stop_fetch_nowr", 64'(wr_cnt - w0), 64'd0);

    // Phase wrap, config applied with start in the same cycle
    a0 = addr_log.size();
    w0 = wr_cnt;
    d0 = done_cnt;
    sq.cfg_valid     = 1'b1;
    sq.cfg_wave      = 2'd2;
    sq.cfg_phase_inc = 8'h40;
    sq.cfg_amp       = 32'h1000_0000;
    sq.cfg_num       = 16'd5;
    sq.start         = 1'b1;
    tick();
    sq.cfg_valid = 1'b0;
    sq.start     = 1'b0;
    wait_idle(40, "t2");
    tick();
    check("t2_writes", 64'(wr_cnt - w0), 64'd5);
    check("t2_fetches", 64'(addr_log.size() - a0), 64'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_addr%0d", i), 64'(addr_log[a0 + i]), 64'(exp_wrap[i]));
    end
    check("t2_sel", 64'(last_sel), 64'd2);
    check("t2_done_once", 64'(done_cnt - d0), 64'd1);
    check("t2_done_after_last", 64'(done_cyc - last_wr_cyc), 64'd1);
    check("t2_done_in_idle", 64'(done_busy), 64'd0);

    // Scaling, truncation and saturation
    run_one(32'h2000_0000, 32'hF000_0000, 32'hE000_0000, "t3_neg");
    run_one(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, "t3_sat_pos");
    run_one(32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000, "t3_sat_neg");
    run_one(32'h4000_0000, 32'h2000_0000, 32'h7FFF_FFFF, "t3_plus8");
    run_one(32'h4000_0000, 32'hE000_0000, 32'h8000_0000, "t3_minus8");
    run_one(32'h3000_0000, 32'h0800_0000, 32'h1800_0000, "t3_gain3");
    run_one(32'h0000_0003, 32'h0800_0000, 32'h0000_0001, "t3_trunc_pos");
    run_one(32'hFFFF_FFFD, 32'h0800_0000, 32'hFFFF_FFFE, "t3_trunc_neg");

    // Back-pressure: 10 stalled cycles in PUSH
    set_cfg(2'd0, 8'd1, 32'h1000_0000, 16'd3);
    lut_value = 32'h0800_0000;
    w0 = wr_cnt;
    d0 = done_cnt;
    sq.fifo_full = 1'b1;
    start_run();
    repeat (2) tick();
    check("t4_stall_busy", 64'(sq.busy), 64'd1);
    check("t4_stall_wr_en", 64'(sq.fifo_wr_en), 64'd0);
    held = sq.fifo_wdata;
    check("t4_held", 64'(held), 64'h0800_0000);
    lut_value = 32'h0F00_0000;
    stall_ok = 1'b1;
    repeat (9) begin
      tick();
      if (sq.fifo_wr_en !== 1'b0 || sq.fifo_wdata !== held || sq.busy !== 1'b1) stall_ok = 1'b0;
    end
    check("t4_stall_stable", 64'(stall_ok), 64'd1);
    check("t4_stall_nowr", 64'(wr_cnt - w0), 64'd0);
    sq.fifo_full = 1'b0;
    #1;
    check("t4_release_wr_en", 64'(sq.fifo_wr_en), 64'd1);
    check("t4_release_wdata", 64'(sq.fifo_wdata), 64'h0800_0000);
    tick();
    check("t4_single_wr_en", 64'(sq.fifo_wr_en), 64'd0);
    check("t4_single_count", 64'(wr_cnt - w0), 64'd1);
    wait_idle(30, "t4");
    tick();
    check("t4_total", 64'(wr_cnt - w0), 64'd3);
    check("t4_done", 64'(done_cnt - d0), 64'd1);
    check("t4_last_wdata", 64'(last_wdata), 64'h0F00_0000);

    // Abort: stop in PUSH while full
    set_cfg(2'd0, 8'd1, 32'h1000_0000, 16'd0);
    lut_value = 32'h0800_0000;
    w0 = wr_cnt;
    d0 = done_cnt;
    sq.fifo_full = 1'b1;
    start_run();
    repeat (2) tick();
    sq.stop = 1'b1;
    #1;
    check("t5a_wr_en", 64'(sq.fifo_wr_en), 64'd0);
    tick();
    sq.stop      = 1'b0;
    sq.fifo_full = 1'b0;
    check("t5a_idle", 64'(sq.busy), 64'd0);
    check("t5a_done", 64'(sq.done), 64'd0);
    tick();
    check("t5a_nowr", 64'(wr_cnt - w0), 64'd0);
    check("t5a_nodone", 64'(done_cnt - d0), 64'd0);

    // Abort: stop on the final sample with room in the FIFO
    set_cfg(2'd0, 8'd1, 32'h1000_0000, 16'd1);
    w0 = wr_cnt;
    d0 = done_cnt;
    start_run();
    repeat (2) tick();
    sq.stop = 1'b1;
    #1;
    check("t5b_wr_en", 64'(sq.fifo_wr_en), 64'd1);
    tick();
    sq.stop = 1'b0;
    check("t5b_idle", 64'(sq.busy), 64'd0);
    check("t5b_done", 64'(sq.done), 64'd0);
    tick();
    check("t5b_one_wr", 64'(wr_cnt - w0), 64'd1);
    check("t5b_nodone", 64'(done_cnt - d0), 64'd0);

    // Abort: stop in SCALE
    set_cfg(2'd0, 8'd1, 32'h1000_0000, 16'd0);
    w0 = wr_cnt;
    start_run();
    tick();
    sq.stop = 1'b1;
    tick();
    sq.stop = 1'b0;
    check("t5c_idle", 64'(sq.busy), 64'd0);
    repeat (2) tick();
    check("t5c_nowr", 64'(wr_cnt - w0), 64'd0);

    // start and stop together in IDLE: start wins
    sq.start = 1'b1;
    sq.stop  = 1'b1;
    tick();
    sq.start = 1'b0;
    sq.stop  = 1'b0;
    check("t5d_busy", 64'(sq.busy), 64'd1);
    check("t5d_lut_en", 64'(sq.lut_en), 64'd1);
    sq.stop = 1'b1;
    tick();
    sq.stop = 1'b0;
    check("t5d_stopped", 64'(sq.busy), 64'd0);

    // Config lockout while busy
    set_cfg(2'd0, 8'd1, 32'h1000_0000, 16'd2);
    lut_value = 32'h0800_0000;
    w0 = wr_cnt;
    start_run();
    sq.cfg_valid = 1'b1;
    sq.cfg_amp   = 32'h3000_0000;
    #1;
    check("t6_cfg_ready", 64'(sq.cfg_ready), 64'd0);
    wait_idle(30, "t6");
    sq.cfg_valid = 1'b0;
    tick();
    check("t6_writes", 64'(wr_cnt - w0), 64'd2);
    check("t6_amp_kept", 64'(last_wdata), 64'h0800_0000);

    // Reset mid-SCALE, then defaults restored
    set_cfg(2'd3, 8'd5, 32'h2000_0000, 16'd0);
    lut_value = 32'h0400_0000;
    w0 = wr_cnt;
    start_run();
    check("t7_sel", 64'(sq.lut_sel), 64'd3);
    repeat (2) tick();
    check("t7_wdata_pre", 64'(sq.fifo_wdata), 64'h0800_0000);
    tick();
    check("t7_addr_inc5", 64'(sq.lut_addr), 64'h05);
    tick();
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy", 64'(sq.busy), 64'd0);
    check("t7_rst_cfg_ready", 64'(sq.cfg_ready), 64'd1);
    check("t7_rst_wdata", 64'(sq.fifo_wdata), 64'd0);
    check("t7_rst_wr_en", 64'(sq.fifo_wr_en), 64'd0);
    check("t7_rst_lut_en", 64'(sq.lut_en), 64'd0);
    check("t7_rst_done", 64'(sq.done), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("t7_no_more_wr", 64'(wr_cnt - w0), 64'd1);
    start_run();
    check("t7_def_sel", 64'(sq.lut_sel), 64'd0);
    check("t7_def_addr0", 64'(sq.lut_addr), 64'h00);
    repeat (2) tick();
    check("t7_def_amp", 64'(sq.fifo_wdata), 64'h0400_0000);
    tick();
    check("t7_def_inc", 64'(sq.lut_addr), 64'h01);
    sq.stop = 1'b1;
    tick();
    sq.stop = 1'b0;
    check("t7_final_idle", 64'(sq.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
